// File: rtl/decode_pkg.sv
// Shared types and constants for the decode fetch queue and its byte ring.
package decode_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fq_state_e;

  localparam int unsigned MAX_X86_INSN_BYTES = 32'd15;

  // Occupancy must represent a completely full ring, hence one bit beyond the pointer.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 32'd1;
  endfunction

endpackage

// File: rtl/decode_byte_ring.sv
// Byte-addressed circular store: one FETCH_BYTES-wide write port and an
// unaligned WINDOW_BYTES-wide read port that wraps at the end of the ring.
module decode_byte_ring
  import decode_pkg::*;
#(
  parameter int unsigned FETCH_BYTES  = 4,
  parameter int unsigned WINDOW_BYTES = 12,
  parameter int unsigned DEPTH_BYTES  = 32,
  localparam int unsigned PTR_W       = $clog2(DEPTH_BYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [PTR_W-1:0]          wr_ptr_i,
  input  logic [FETCH_BYTES*8-1:0]  wr_data_i,
  input  logic [PTR_W-1:0]          rd_ptr_i,
  output logic [WINDOW_BYTES*8-1:0] rd_window_o
);

  logic [7:0] mem_q [DEPTH_BYTES];

  // Byte writes; pointer arithmetic is PTR_W wide so the index wraps for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        mem_q[wr_ptr_i + PTR_W'(i)] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // Unaligned window read starting at rd_ptr_i.
  always_comb begin
    rd_window_o = {(WINDOW_BYTES*8){1'b0}};
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      rd_window_o[8*k +: 8] = mem_q[rd_ptr_i + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/decode_fetch_queue.sv
// Byte-granular prefetch queue feeding the x86 decoder: fixed-size pushes in,
// variable-length retires out, with drain-at-end-of-stream and flush/redirect.
module decode_fetch_queue
  import decode_pkg::*;
#(
  parameter int unsigned FETCH_BYTES  = 4,
  parameter int unsigned WINDOW_BYTES = 12,
  parameter int unsigned DEPTH_BYTES  = 32,
  parameter int unsigned LEN_W        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [31:0]                   flush_offset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FETCH_BYTES*8-1:0]      in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  output logic [WINDOW_BYTES*8-1:0]     out_window,
  output logic [$clog2(DEPTH_BYTES):0]  out_avail,
  output logic [31:0]                   out_offset,
  input  logic                          consume_valid,
  input  logic [LEN_W-1:0]              consume_len,
  output logic                          err
);

  localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);
  localparam int unsigned OCC_W = occ_width(DEPTH_BYTES);
  localparam int unsigned CMP_W = OCC_W + LEN_W;

  if (((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) ||
      (DEPTH_BYTES < WINDOW_BYTES + FETCH_BYTES)) begin : g_bad_cfg
    $error("decode_fetch_queue: DEPTH_BYTES must be a power of two >= WINDOW_BYTES+FETCH_BYTES");
  end

  fq_state_e               state_q;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [31:0]             offset_q, offset_d;
  logic                    err_q, err_d;

  logic                    push_s, legal_s, illegal_s;
  logic [OCC_W-1:0]        occ_add_s, occ_sub_s;
  logic [WINDOW_BYTES*8-1:0] ring_window_s;

  decode_byte_ring #(
    .FETCH_BYTES  (FETCH_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES),
    .DEPTH_BYTES  (DEPTH_BYTES)
  ) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (push_s & ~flush),
    .wr_ptr_i    (wr_ptr_q),
    .wr_data_i   (in_data),
    .rd_ptr_i    (rd_ptr_q),
    .rd_window_o (ring_window_s)
  );

  // Handshake and window status, all derived from registered state.
  always_comb begin
    in_ready  = (state_q == RUN) &&
                ((OCC_W'(DEPTH_BYTES) - occ_q) >= OCC_W'(FETCH_BYTES));
    out_avail = (occ_q >= OCC_W'(WINDOW_BYTES)) ? OCC_W'(WINDOW_BYTES) : occ_q;
    case (state_q)
      RUN:     out_valid = (occ_q >= OCC_W'(WINDOW_BYTES));
      DRAIN:   out_valid = (occ_q != {OCC_W{1'b0}});
      DONE:    out_valid = 1'b0;
      default: out_valid = 1'b0;
    endcase
  end

  // Bytes beyond the valid count are forced to zero so stale ring data never leaks.
  always_comb begin
    out_window = {(WINDOW_BYTES*8){1'b0}};
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      if (OCC_W'(k) < out_avail) begin
        out_window[8*k +: 8] = ring_window_s[8*k +: 8];
      end else begin
        out_window[8*k +: 8] = 8'h00;
      end
    end
  end

  assign push_s     = in_valid & in_ready;
  assign legal_s    = consume_valid & out_valid & (consume_len != {LEN_W{1'b0}}) &
                      (CMP_W'(consume_len) <= CMP_W'(out_avail));
  assign illegal_s  = consume_valid & ~legal_s;
  assign occ_add_s  = push_s  ? OCC_W'(FETCH_BYTES) : {OCC_W{1'b0}};
  assign occ_sub_s  = legal_s ? OCC_W'(consume_len) : {OCC_W{1'b0}};
  assign out_offset = offset_q;
  assign err        = err_q;

  // Next-state datapath; flush overrides push and consume but keeps err.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    offset_d = offset_q;
    err_d    = err_q;
    if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      occ_d    = {OCC_W{1'b0}};
      offset_d = flush_offset;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(FETCH_BYTES);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (legal_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(consume_len);
        offset_d = offset_q + 32'(consume_len);
      end else begin
        rd_ptr_d = rd_ptr_q;
        offset_d = offset_q;
      end
      occ_d = occ_q + occ_add_s - occ_sub_s;
      if (illegal_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers and stream FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      offset_q <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      offset_q <= offset_d;
      err_q    <= err_d;
      if (flush) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          RUN:     if (push_s && in_last) state_q <= DRAIN;
          DRAIN:   if (occ_d == {OCC_W{1'b0}}) state_q <= DONE;
          DONE:    state_q <= DONE;
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Directed bench for decode_fetch_queue: fill, push+consume, wrap, drain,
// illegal consume, flush priority and asynchronous reset mid-drain.
module tb_decode_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_offset = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic [95:0] out_window;
  logic [5:0]  out_avail;
  logic [31:0] out_offset;
  logic        consume_valid = 1'b0;
  logic [3:0]  consume_len = 4'd0;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_offset(flush_offset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_window(out_window), .out_avail(out_avail),
    .out_offset(out_offset), .consume_valid(consume_valid), .consume_len(consume_len),
    .err(err)
  );

  function automatic logic [31:0] chunk(input int j);
    logic [31:0] c = 32'h0;
    for (int b = 0; b < 4; b++) c[8*b +: 8] = 8'(4*j + b);
    return c;
  endfunction

  function automatic logic [95:0] win_of(input int base, input int n);
    logic [95:0] w = 96'h0;
    for (int k = 0; k < 12; k++) if (k < n) w[8*k +: 8] = 8'(base + k);
    return w;
  endfunction

  // Apply one cycle of inputs at a negedge, return at the following negedge.
  task automatic drive(input logic pv, input logic [31:0] pd, input logic pl,
                       input logic cv, input logic [3:0] cl,
                       input logic fl, input logic [31:0] fo);
    in_valid = pv; in_data = pd; in_last = pl;
    consume_valid = cv; consume_len = cl; flush = fl; flush_offset = fo;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; consume_valid = 1'b0; consume_len = 4'd0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (out_window !== 96'h0) begin miscompares++; $display("FAIL reset_window got %h want 0", out_window); end
    vectors++; if (out_avail !== 6'd0) begin miscompares++; $display("FAIL reset_avail got %0d want 0", out_avail); end
    vectors++; if (out_offset !== 32'h0) begin miscompares++; $display("FAIL reset_offset got %h want 0", out_offset); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    drive(1'b1, 32'h03020100, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd4) begin miscompares++; $display("FAIL fill1_avail got %0d want 4", out_avail); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fill1_valid got %b want 0", out_valid); end
    drive(1'b1, 32'h07060504, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    drive(1'b1, 32'h0B0A0908, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid got %b want 1", out_valid); end
    vectors++; if (out_window !== 96'h0B0A09080706050403020100) begin miscompares++; $display("FAIL fill_window got %h want 0b0a09080706050403020100", out_window); end
    vectors++; if (out_avail !== 6'd12) begin miscompares++; $display("FAIL fill_avail got %0d want 12", out_avail); end
    vectors++; if (out_offset !== 32'h0) begin miscompares++; $display("FAIL fill_offset got %h want 0", out_offset); end
  endtask

  task automatic test_push_consume();
    drive(1'b1, 32'h0F0E0D0C, 1'b0, 1'b1, 4'd5, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd11) begin miscompares++; $display("FAIL pc_avail got %0d want 11", out_avail); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pc_valid got %b want 0", out_valid); end
    vectors++; if (out_window[7:0] !== 8'h05) begin miscompares++; $display("FAIL pc_byte0 got %h want 05", out_window[7:0]); end
    vectors++; if (out_window !== 96'h000F0E0D0C0B0A0908070605) begin miscompares++; $display("FAIL pc_window got %h want 000f0e0d0c0b0a0908070605", out_window); end
    vectors++; if (out_offset !== 32'd5) begin miscompares++; $display("FAIL pc_offset got %0d want 5", out_offset); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h0);
  endtask

  task automatic test_wrap();
    int off = 0;
    for (int j = 0; j < 3; j++) drive(1'b1, chunk(j), 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_window !== win_of(0, 12)) begin miscompares++; $display("FAIL wrap_start got %h want %h", out_window, win_of(0, 12)); end
    for (int j = 3; j < 10; j++) begin
      drive(1'b1, chunk(j), (j == 9), 1'b1, 4'd4, 1'b0, 32'h0);
      off += 4;
      vectors++; if (out_offset !== 32'(off)) begin miscompares++; $display("FAIL wrap_offset[%0d] got %0d want %0d", j, out_offset, off); end
      vectors++; if (out_window !== win_of(off, 12)) begin miscompares++; $display("FAIL wrap_window[%0d] got %h want %h", j, out_window, win_of(off, 12)); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd4, 1'b0, 32'h0);
      off += 4;
      vectors++; if (out_avail !== 6'(8 - 4*i)) begin miscompares++; $display("FAIL wrap_drain_avail[%0d] got %0d want %0d", i, out_avail, 8 - 4*i); end
      vectors++; if (out_window !== win_of(off, 8 - 4*i)) begin miscompares++; $display("FAIL wrap_drain_window[%0d] got %h want %h", i, out_window, win_of(off, 8 - 4*i)); end
    end
    vectors++; if (out_offset !== 32'd40) begin miscompares++; $display("FAIL wrap_final_offset got %0d want 40", out_offset); end
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL wrap_done got valid=%b ready=%b want 0 0", out_valid, in_ready); end
  endtask

  task automatic test_drain();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h0);
    drive(1'b1, 32'h03020100, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    drive(1'b1, 32'h00000504, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid got %b want 1", out_valid); end
    vectors++; if (out_avail !== 6'd8) begin miscompares++; $display("FAIL drain_avail got %0d want 8", out_avail); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL drain_ready got %b want 0", in_ready); end
    vectors++; if (out_window !== 96'h000000000000050403020100) begin miscompares++; $display("FAIL drain_window got %h want 000000000000050403020100", out_window); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd8, 1'b0, 32'h0);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL done_status got valid=%b ready=%b want 0 0", out_valid, in_ready); end
    vectors++; if (out_offset !== 32'd8) begin miscompares++; $display("FAIL done_offset got %0d want 8", out_offset); end
    drive(1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd0 || out_window !== 96'h0) begin miscompares++; $display("FAIL done_push_ignored got avail=%0d window=%h want 0 0", out_avail, out_window); end
  endtask

  task automatic test_illegal();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h0);
    for (int j = 0; j < 3; j++) drive(1'b1, chunk(j), 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_pre_err got %b want 0", err); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 1'b0, 32'h0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_len0_err got %b want 1", err); end
    vectors++; if (out_avail !== 6'd12 || out_offset !== 32'h0) begin miscompares++; $display("FAIL illegal_len0_state got avail=%0d off=%0d want 12 0", out_avail, out_offset); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd13, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd12 || out_offset !== 32'h0) begin miscompares++; $display("FAIL illegal_len13_state got avail=%0d off=%0d want 12 0", out_avail, out_offset); end
    vectors++; if (out_window !== win_of(0, 12)) begin miscompares++; $display("FAIL illegal_len13_window got %h want %h", out_window, win_of(0, 12)); end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 4'd12, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd0 || out_offset !== 32'd12) begin miscompares++; $display("FAIL consume12 got avail=%0d off=%0d want 0 12", out_avail, out_offset); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_flush();
    for (int j = 0; j < 3; j++) drive(1'b1, chunk(j), 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd12) begin miscompares++; $display("FAIL flush_pre_avail got %0d want 12", out_avail); end
    drive(1'b1, chunk(3), 1'b0, 1'b1, 4'd4, 1'b1, 32'h00401000);
    vectors++; if (out_avail !== 6'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_occ got avail=%0d valid=%b want 0 0", out_avail, out_valid); end
    vectors++; if (out_offset !== 32'h00401000) begin miscompares++; $display("FAIL flush_offset got %h want 00401000", out_offset); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", in_ready); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL flush_err got %b want 1", err); end
    drive(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_avail !== 6'd4 || out_window !== 96'h0000000000000000DDCCBBAA) begin miscompares++; $display("FAIL flush_repush got avail=%0d window=%h want 4 ddccbbaa", out_avail, out_window); end
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, 32'h44332211, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
    vectors++; if (out_valid !== 1'b1 || out_avail !== 6'd8 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_drain got valid=%b avail=%0d ready=%b want 1 8 0", out_valid, out_avail, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", out_valid); end
    vectors++; if (out_window !== 96'h0 || out_avail !== 6'd0) begin miscompares++; $display("FAIL arst_window got %h avail=%0d want 0 0", out_window, out_avail); end
    vectors++; if (out_offset !== 32'h0 || err !== 1'b0) begin miscompares++; $display("FAIL arst_offset_err got %h err=%b want 0 0", out_offset, err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_push_consume();
    test_wrap();
    test_drain();
    test_illegal();
    test_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
